// File: rtl/accumulator_bank.sv
// accumulator_bank: per-column saturating partial-sum row store with compensation merge
// and a valid/ready drain sequencer that optionally clears rows as they leave.
module accumulator_bank #(
  parameter int NUM_COL = 4,
  parameter int DEPTH = 8,
  parameter int PSUM_W = 45,
  parameter int CPSUM_W = 14,
  parameter bit CLR_ON_DRAIN = 1'b1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        acc_wr_en,
  input  logic [ADDR_W-1:0]           acc_wr_addr,
  input  logic                        acc_first,
  input  logic [NUM_COL*PSUM_W-1:0]   psum_in,
  input  logic                        cacc_wr_en,
  input  logic [ADDR_W-1:0]           cacc_wr_addr,
  input  logic [NUM_COL*CPSUM_W-1:0]  cpsum_in,
  input  logic                        drain_start,
  output logic                        drain_busy,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ADDR_W-1:0]           out_addr,
  output logic [NUM_COL*PSUM_W-1:0]   psum_out,
  output logic                        drain_done
);
  typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;
  state_t state, state_n;
  logic [NUM_COL*PSUM_W-1:0] mem [DEPTH];
  logic [NUM_COL*PSUM_W-1:0] acc_old, acc_val, cacc_val;
  logic [ADDR_W-1:0] rd_ptr;
  logic armed, load, hs, clr, collide;
  function automatic logic [PSUM_W-1:0] sat(input logic [PSUM_W:0] s);
    return (s[PSUM_W] == s[PSUM_W-1]) ? s[PSUM_W-1:0] : {s[PSUM_W], {(PSUM_W-1){~s[PSUM_W]}}};
  endfunction
  function automatic logic [PSUM_W:0] sx(input logic [PSUM_W-1:0] v);
    return {v[PSUM_W-1], v};
  endfunction
  function automatic logic [PSUM_W-1:0] csx(input logic [CPSUM_W-1:0] v);
    return PSUM_W'($signed(v));
  endfunction
  // A row leaving on this cycle's handshake reads as zero to a same-cycle host add.
  always_comb begin
    hs = out_valid && out_ready;
    clr = CLR_ON_DRAIN && hs;
    collide = acc_wr_en && cacc_wr_en && (acc_wr_addr == cacc_wr_addr);
    load = (state == RUN) && armed && (!out_valid || out_ready);
    acc_old = (clr && out_addr == acc_wr_addr) ? '0 : mem[acc_wr_addr];
    acc_val = '0;
    cacc_val = '0;
    for (int c = 0; c < NUM_COL; c++) begin
      cacc_val[c*PSUM_W +: PSUM_W] = csx(cpsum_in[c*CPSUM_W +: CPSUM_W]);
      acc_val[c*PSUM_W +: PSUM_W] = collide ? sat(sx(cacc_val[c*PSUM_W +: PSUM_W]) + sx(psum_in[c*PSUM_W +: PSUM_W]))
        : acc_first ? psum_in[c*PSUM_W +: PSUM_W]
        : sat(sx(acc_old[c*PSUM_W +: PSUM_W]) + sx(psum_in[c*PSUM_W +: PSUM_W]));
    end
    state_n = (state == IDLE && drain_start) ? RUN
      : (state == RUN && load && rd_ptr == ADDR_W'(DEPTH-1)) ? LAST
      : (state == LAST && hs) ? IDLE : state;
  end
  always_ff @(posedge clk)
    for (int r = 0; r < DEPTH; r++)
      if (acc_wr_en && acc_wr_addr == ADDR_W'(r)) mem[r] <= acc_val;
      else if (cacc_wr_en && cacc_wr_addr == ADDR_W'(r)) mem[r] <= cacc_val;
      else if (clr && out_addr == ADDR_W'(r)) mem[r] <= '0;
  // armed delays the first load by one cycle after entering RUN.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rd_ptr <= '0;
      armed <= 1'b0;
      out_valid <= 1'b0;
      out_addr <= '0;
      psum_out <= '0;
      drain_done <= 1'b0;
    end else begin
      state <= state_n;
      armed <= state == RUN;
      drain_done <= state == LAST && hs;
      if (state == IDLE && drain_start) rd_ptr <= '0;
      else if (load) rd_ptr <= rd_ptr + 1'b1;
      if (load) begin
        out_valid <= 1'b1;
        out_addr <= rd_ptr;
        psum_out <= mem[rd_ptr];
      end else if (state == LAST && hs) out_valid <= 1'b0;
    end
  assign drain_busy = state != IDLE;
endmodule
